// File: rtl/sha3_digest_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pkg
// Description : Shared types and digest-size constants for the SHA3 digest
//               serializer.
// Revision    : 1.0
// ============================================================================
package sha3_pkg;

    typedef logic [63:0] lane_t;
    typedef logic [31:0] word_t;

    localparam int SHA3_224_WORDS = 7;
    localparam int SHA3_256_WORDS = 8;
    localparam int SHA3_384_WORDS = 12;
    localparam int SHA3_512_WORDS = 16;

    // Two rows of five 64-bit lanes bound the longest digest.
    localparam int c_MAX_WORDS = 20;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sha3_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sha3_digest_serializer
// Description : Captures the digest lanes of the final Keccak state on a
//               sample strobe and streams them as 32-bit words (valid/ready).
// Revision    : 1.0
// ============================================================================
module sha3_digest_serializer
    import sha3_pkg::*;
#(
    parameter int OUT_WORDS = SHA3_256_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  lane_t       isa [5],
    input  lane_t       isb [5],
    input  lane_t       isc [5],
    input  lane_t       isd [5],
    input  lane_t       ise [5],
    input  logic        sample,
    output logic        iready,
    output word_t       odata,
    output logic        ovalid,
    output logic        olast,
    input  logic        oready,
    output logic        odropped,
    output logic [15:0] ocount
);

    localparam int                 c_IDX_W    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(OUT_WORDS - 1);
    localparam logic               c_SINGLE   = (OUT_WORDS == 1);

    if (OUT_WORDS < 1 || OUT_WORDS > c_MAX_WORDS) begin : g_bad_out_words
        $error("sha3_digest_serializer: OUT_WORDS must be in 1..20");
    end

    state_t             r_state;
    logic [c_IDX_W-1:0] r_idx;
    word_t              r_data;
    logic               r_valid;
    logic               r_last;
    logic               r_dropped;
    logic [15:0]        r_count;
    word_t              r_words [OUT_WORDS];

    word_t              w_words [OUT_WORDS];
    word_t              w_next_data;
    logic [c_IDX_W-1:0] w_next_idx;
    logic               w_iready;
    logic               w_load;
    logic               w_unused;

    // Word k is the low (k even) or high (k odd) half of lane k/2.
    for (genvar k = 0; k < OUT_WORDS; k++) begin : g_word
        if (k / 2 < 5) begin : g_row_a
            assign w_words[k] = isa[k/2][32*(k%2) +: 32];
        end else begin : g_row_b
            assign w_words[k] = isb[k/2-5][32*(k%2) +: 32];
        end
    end

    // Rows c..e and the undigested lanes are present only for port parity.
    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_unused = w_unused ^ (^isa[i]) ^ (^isb[i]) ^ (^isc[i]) ^ (^isd[i]) ^ (^ise[i]);
        end
    end

    assign w_iready   = (r_state == IDLE) || ((r_state == SEND) && r_last && oready);
    assign w_load     = sample && w_iready;
    assign w_next_idx = r_idx + 1'b1;

    always_comb begin
        w_next_data = '0;
        for (int i = 0; i < OUT_WORDS; i++) begin
            if (w_next_idx == c_IDX_W'(i)) begin
                w_next_data = r_words[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load && !rst) begin
            r_words <= w_words;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_dropped <= 1'b0;
            r_count   <= '0;
        end else begin
            r_dropped <= sample && !w_iready;

            case (r_state)
                IDLE: ;
                SEND: begin
                    if (oready) begin
                        if (r_last) begin
                            r_count <= r_count + 16'd1;
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_data <= w_next_data;
                            r_last <= (w_next_idx == c_LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A capture overrides the IDLE return so back-to-back digests have no bubble.
            if (w_load) begin
                r_state <= SEND;
                r_idx   <= '0;
                r_data  <= w_words[0];
                r_valid <= 1'b1;
                r_last  <= c_SINGLE;
            end
        end
    end

    assign iready   = w_iready;
    assign odata    = r_data;
    assign ovalid   = r_valid;
    assign olast    = r_last;
    assign odropped = r_dropped;
    assign ocount   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sha3_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_digest_serializer
// Description : Scoreboard bench for the SHA3 digest serializer at 8, 7, 16
//               and 1 words per digest.
// Revision    : 1.0
// ============================================================================
module tb_sha3_digest_serializer;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       isa [5];
    logic [63:0]       isb [5];
    logic [63:0]       isc [5];
    logic [63:0]       isd [5];
    logic [63:0]       ise [5];
    logic [3:0]        sample_v;
    logic [3:0]        oready_v;
    logic [3:0]        iready_v;
    logic [3:0]        ovalid_v;
    logic [3:0]        olast_v;
    logic [3:0]        odropped_v;
    logic [3:0][31:0]  odata_v;
    logic [3:0][15:0]  ocount_v;

    logic [32:0]       exp_q [4][$];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    sha3_digest_serializer #(.OUT_WORDS(8)) u_dut8 (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_v[0]), .iready(iready_v[0]), .odata(odata_v[0]), .ovalid(ovalid_v[0]),
        .olast(olast_v[0]), .oready(oready_v[0]), .odropped(odropped_v[0]), .ocount(ocount_v[0]));

    sha3_digest_serializer #(.OUT_WORDS(7)) u_dut7 (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_v[1]), .iready(iready_v[1]), .odata(odata_v[1]), .ovalid(ovalid_v[1]),
        .olast(olast_v[1]), .oready(oready_v[1]), .odropped(odropped_v[1]), .ocount(ocount_v[1]));

    sha3_digest_serializer #(.OUT_WORDS(16)) u_dut16 (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_v[2]), .iready(iready_v[2]), .odata(odata_v[2]), .ovalid(ovalid_v[2]),
        .olast(olast_v[2]), .oready(oready_v[2]), .odropped(odropped_v[2]), .ocount(ocount_v[2]));

    sha3_digest_serializer #(.OUT_WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_v[3]), .iready(iready_v[3]), .odata(odata_v[3]), .ovalid(ovalid_v[3]),
        .olast(olast_v[3]), .oready(oready_v[3]), .odropped(odropped_v[3]), .ocount(ocount_v[3]));

    // Monitor: every accepted word is compared against the head of its queue.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && ovalid_v[i] && oready_v[i]) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected dut%0d: got last=%b data=%h, none expected",
                             i, olast_v[i], odata_v[i]);
                end else begin
                    logic [32:0] e;
                    e = exp_q[i].pop_front();
                    if ({olast_v[i], odata_v[i]} !== e) begin
                        errors++;
                        $display("FAIL word dut%0d: got last=%b data=%h, expected last=%b data=%h",
                                 i, olast_v[i], odata_v[i], e[32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Lane L = {base+2L+1, base+2L}, so digest word k is simply base+k.
    task automatic set_pattern(input logic [31:0] base);
        for (int l = 0; l < 10; l++) begin
            logic [63:0] lane;
            lane = {base + 32'(2*l + 1), base + 32'(2*l)};
            if (l < 5) isa[l] = lane;
            else       isb[l-5] = lane;
        end
        for (int l = 0; l < 5; l++) begin
            isc[l] = {$urandom, $urandom};
            isd[l] = {$urandom, $urandom};
            ise[l] = {$urandom, $urandom};
        end
    endtask

    task automatic push_pattern(input int inst, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q[inst].push_back({(k == n - 1), base + 32'(k)});
        end
    endtask

    initial begin
        rst      = 1'b1;
        sample_v = 4'b0001;
        oready_v = 4'b1111;
        set_pattern(32'h0);
        tick();
        tick();
        rst      = 1'b0;
        sample_v = 4'b0000;
        tick();

        chk("reset_ovalid",   32'(ovalid_v[0]),   32'h0);
        chk("reset_olast",    32'(olast_v[0]),    32'h0);
        chk("reset_odata",    odata_v[0],         32'h0);
        chk("reset_odropped", 32'(odropped_v[0]), 32'h0);
        chk("reset_ocount",   32'(ocount_v[0]),   32'h0);
        chk("reset_iready",   32'(iready_v[0]),   32'h1);

        // SHA3-256("") = a7ffc6f8bf1ed766 51c14756a061d662 f580ff4de43b49fa 82d80a4b80f8434a
        set_pattern(32'h5555_0000);
        isa[0] = 64'h66d71ebff8c6ffa7;
        isa[1] = 64'h62d661a05647c151;
        isa[2] = 64'hfa493be44dff80f5;
        isa[3] = 64'h4a43f8804b0ad882;
        exp_q[0].push_back({1'b0, 32'hf8c6ffa7});
        exp_q[0].push_back({1'b0, 32'h66d71ebf});
        exp_q[0].push_back({1'b0, 32'h5647c151});
        exp_q[0].push_back({1'b0, 32'h62d661a0});
        exp_q[0].push_back({1'b0, 32'h4dff80f5});
        exp_q[0].push_back({1'b0, 32'hfa493be4});
        exp_q[0].push_back({1'b0, 32'h4b0ad882});
        exp_q[0].push_back({1'b1, 32'h4a43f880});
        sample_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        chk("first_word_latency", odata_v[0], 32'hf8c6ffa7);
        chk("send_iready_low", 32'(iready_v[0]), 32'h0);
        repeat (8) tick();
        chk("empty_ovalid_drop", 32'(ovalid_v[0]), 32'h0);
        chk("empty_ocount",      32'(ocount_v[0]), 32'h1);

        // Backpressure at word 2, dropped strobe at word 3
        set_pattern(32'h1000_0000);
        push_pattern(0, 32'h1000_0000, 8);
        sample_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        tick();
        tick();
        oready_v[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_data",  odata_v[0],          32'h1000_0002);
            chk("bp_hold_valid", 32'(ovalid_v[0]),    32'h1);
        end
        oready_v[0] = 1'b1;
        tick();
        chk("bp_resume", odata_v[0], 32'h1000_0003);
        set_pattern(32'hdead_0000);
        sample_v[0] = 1'b1;
        chk("drop_iready", 32'(iready_v[0]), 32'h0);
        tick();
        sample_v[0] = 1'b0;
        chk("drop_pulse", 32'(odropped_v[0]), 32'h1);
        tick();
        chk("drop_pulse_end", 32'(odropped_v[0]), 32'h0);
        tick();
        tick();
        chk("bp_last_flag", 32'(olast_v[0]), 32'h1);

        // Back-to-back capture on the last-word handshake
        set_pattern(32'h2000_0000);
        push_pattern(0, 32'h2000_0000, 8);
        sample_v[0] = 1'b1;
        chk("b2b_iready", 32'(iready_v[0]), 32'h1);
        tick();
        sample_v[0] = 1'b0;
        chk("b2b_ovalid", 32'(ovalid_v[0]), 32'h1);
        chk("b2b_word0",  odata_v[0],       32'h2000_0000);
        chk("b2b_ocount", 32'(ocount_v[0]), 32'h2);

        // Reset at word 5 aborts the digest
        repeat (5) tick();
        chk("pre_reset_word5", odata_v[0], 32'h2000_0005);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q[0].delete();
        chk("midrst_ovalid", 32'(ovalid_v[0]), 32'h0);
        chk("midrst_ocount", 32'(ocount_v[0]), 32'h0);
        chk("midrst_iready", 32'(iready_v[0]), 32'h1);
        set_pattern(32'h3000_0000);
        push_pattern(0, 32'h3000_0000, 8);
        sample_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        chk("restart_word0", odata_v[0], 32'h3000_0000);
        repeat (8) tick();
        chk("restart_ocount", 32'(ocount_v[0]), 32'h1);

        // Truncations: 7, 16 and 1 words
        set_pattern(32'h4000_0000);
        push_pattern(1, 32'h4000_0000, 7);
        push_pattern(2, 32'h4000_0000, 16);
        push_pattern(3, 32'h4000_0000, 1);
        sample_v[3:1] = 3'b111;
        tick();
        sample_v[3:1] = 3'b000;
        chk("w1_olast", 32'(olast_v[3]), 32'h1);
        repeat (17) tick();
        chk("w7_ocount",  32'(ocount_v[1]), 32'h1);
        chk("w16_ocount", 32'(ocount_v[2]), 32'h1);
        chk("w1_ocount",  32'(ocount_v[3]), 32'h1);
        chk("w16_idle",   32'(ovalid_v[2]), 32'h0);

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("queue_empty_dut%0d", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
